// File: rtl/serial_link_physical_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : serial_link_physical_rx_os
//  Description : Oversampling receive PHY. Synchronizes the forwarded clock
//                and lane data into clk_i, detects forwarded-clock edges,
//                rebuilds DDR/SDR words and buffers them in a small FIFO with
//                a valid/ready interface and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_link_physical_rx_os #(
    parameter int unsigned NumLanes         = 8,
    parameter int unsigned SyncStages       = 2,
    parameter int unsigned FifoDepth        = 8,
    parameter bit          ddr_sdr_selector = 1'b1
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           flush_i,
    input  logic                                           ddr_rcv_clk_i,
    input  logic [NumLanes-1:0]                            ddr_i,
    output logic [NumLanes*(ddr_sdr_selector ? 2 : 1)-1:0] data_in_o,
    output logic                                           data_in_valid_o,
    input  logic                                           data_in_ready_i,
    output logic                                           overflow_o
);

    localparam int unsigned W  = NumLanes * (ddr_sdr_selector ? 2 : 1);
    localparam int unsigned AW = $clog2(FifoDepth);

    // Synchronizer chains: clock and data see identical depth so the
    // sampled data stays aligned with the detected edge.
    logic [SyncStages-1:0]               clk_sync_q, clk_sync_d;
    logic [SyncStages-1:0][NumLanes-1:0] dat_sync_q, dat_sync_d;
    logic                                prev_q, prev_d;
    logic                                sclk;
    logic [NumLanes-1:0]                 sdat;
    logic                                rise;

    // FIFO state
    logic [FifoDepth-1:0][W-1:0] mem_q, mem_d;
    logic [AW:0]                 wptr_q, wptr_d;
    logic [AW:0]                 rptr_q, rptr_d;
    logic                        overflow_q, overflow_d;
    logic [W-1:0]                word;
    logic                        push;
    logic                        pop;
    logic                        empty;
    logic                        full;

    assign sclk = clk_sync_q[SyncStages-1];
    assign sdat = dat_sync_q[SyncStages-1];
    assign rise = sclk & ~prev_q;

    // Shift the raw pins into the synchronizers and remember the last clock level
    always_comb begin
        clk_sync_d = {clk_sync_q[SyncStages-2:0], ddr_rcv_clk_i};
        dat_sync_d = {dat_sync_q[SyncStages-2:0], ddr_i};
        prev_d     = sclk;
    end

    // Synchronizer registers; clock path idles high like the transmitter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= '1;
            dat_sync_q <= '0;
            prev_q     <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            prev_q     <= prev_d;
        end
    end

    generate
        if (ddr_sdr_selector) begin : g_ddr
            logic                fall;
            logic [NumLanes-1:0] half_q, half_d;

            assign fall = ~sclk & prev_q;
            assign word = {sdat, half_q};

            // Capture the low half of the word on the falling edge
            always_comb begin
                half_d = half_q;
                if (flush_i) begin
                    half_d = '0;
                end else if (fall) begin
                    half_d = sdat;
                end
            end

            // Half-word register
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    half_q <= '0;
                end else begin
                    half_q <= half_d;
                end
            end
        end else begin : g_sdr
            assign word = sdat;
        end
    endgenerate

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = rise & ~flush_i;
    assign pop   = ~empty & data_in_ready_i;

    // FIFO update: a pop frees the slot a simultaneous push needs, so a full
    // FIFO still accepts a word when the consumer reads in the same cycle
    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push) begin
                if (!full || pop) begin
                    mem_d[wptr_q[AW-1:0]] = word;
                    wptr_d                = wptr_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // FIFO storage, pointers and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_in_o       = mem_q[rptr_q[AW-1:0]];
    assign data_in_valid_o = ~empty;
    assign overflow_o      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_physical_rx_os.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_link_physical_rx_os
//  Description : Self-checking bench for serial_link_physical_rx_os, one DDR
//                and one SDR instance, checked against a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_link_physical_rx_os;

    localparam int SYNC  = 2;
    localparam int DEPTH = 8;

    typedef struct packed {
        int unsigned at;
        logic        rise;
        logic [7:0]  d;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        pclk_d, pclk_s;
    logic [7:0]  pdat_d, pdat_s;
    logic        rdy_d, rdy_s;
    logic [15:0] dout_d;
    logic [7:0]  dout_s;
    logic        val_d, val_s;
    logic        ovf_d, ovf_s;

    int          n_checks;
    int          n_errors;
    int unsigned pc;
    int          pops_d, pops_s;
    bit          rand_rdy;

    // Reference model state
    ev_t         evq_d[$];
    ev_t         evq_s[$];
    logic [15:0] mq_d[$];
    logic [7:0]  mq_s[$];
    logic [7:0]  half_m;
    bit          ovf_m_d, ovf_m_s;

    serial_link_physical_rx_os #(
        .NumLanes(8), .SyncStages(SYNC), .FifoDepth(DEPTH), .ddr_sdr_selector(1'b1)
    ) u_dut_ddr (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .ddr_rcv_clk_i(pclk_d), .ddr_i(pdat_d),
        .data_in_o(dout_d), .data_in_valid_o(val_d),
        .data_in_ready_i(rdy_d), .overflow_o(ovf_d)
    );

    serial_link_physical_rx_os #(
        .NumLanes(8), .SyncStages(SYNC), .FifoDepth(DEPTH), .ddr_sdr_selector(1'b0)
    ) u_dut_sdr (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .ddr_rcv_clk_i(pclk_s), .ddr_i(pdat_s),
        .data_in_o(dout_s), .data_in_valid_o(val_s),
        .data_in_ready_i(rdy_s), .overflow_o(ovf_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        evq_d.delete();
        evq_s.delete();
        mq_d.delete();
        mq_s.delete();
        half_m  = '0;
        ovf_m_d = 1'b0;
        ovf_m_s = 1'b0;
    endtask

    // One clk_i cycle of the word-level model: an edge driven at the pins
    // lands in the FIFO SYNC+1 rising edges later.
    task automatic model_step();
        ev_t e;
        bit  has;
        bit  pop;
        pc++;
        if (!rst_n) return;
        has = 1'b0;
        if (evq_d.size() > 0 && evq_d[0].at == pc) begin
            e   = evq_d.pop_front();
            has = 1'b1;
        end
        if (flush) begin
            mq_d.delete();
            half_m  = '0;
            ovf_m_d = 1'b0;
        end else begin
            pop = (mq_d.size() > 0) && rdy_d;
            if (pop) void'(mq_d.pop_front());
            if (has && !e.rise) half_m = e.d;
            if (has && e.rise) begin
                if (mq_d.size() < DEPTH) mq_d.push_back({e.d, half_m});
                else ovf_m_d = 1'b1;
            end
        end
        has = 1'b0;
        if (evq_s.size() > 0 && evq_s[0].at == pc) begin
            e   = evq_s.pop_front();
            has = 1'b1;
        end
        if (flush) begin
            mq_s.delete();
            ovf_m_s = 1'b0;
        end else begin
            pop = (mq_s.size() > 0) && rdy_s;
            if (pop) void'(mq_s.pop_front());
            if (has && e.rise) begin
                if (mq_s.size() < DEPTH) mq_s.push_back(e.d);
                else ovf_m_s = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && !flush && val_d && rdy_d) pops_d++;
            if (rst_n && !flush && val_s && rdy_s) pops_s++;
            model_step();
        end
    end

    // Continuous comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            check("ddr_valid", {31'd0, val_d}, {31'd0, mq_d.size() != 0});
            if (mq_d.size() != 0) check("ddr_data", {16'd0, dout_d}, {16'd0, mq_d[0]});
            check("ddr_ovf", {31'd0, ovf_d}, {31'd0, ovf_m_d});
            check("sdr_valid", {31'd0, val_s}, {31'd0, mq_s.size() != 0});
            if (mq_s.size() != 0) check("sdr_data", {24'd0, dout_s}, {24'd0, mq_s[0]});
            check("sdr_ovf", {31'd0, ovf_s}, {31'd0, ovf_m_s});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_rdy) begin
                rdy_d = 1'($urandom_range(0, 1));
                rdy_s = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drive_edge(input bit m, input bit lvl, input logic [7:0] d);
        ev_t e;
        e.at   = pc + SYNC + 1;
        e.rise = lvl;
        e.d    = d;
        if (!m) begin
            pclk_d = lvl;
            pdat_d = d;
            evq_d.push_back(e);
        end else begin
            pclk_s = lvl;
            pdat_s = d;
            evq_s.push_back(e);
        end
    endtask

    task automatic send_word(input bit m, input logic [7:0] lo, input logic [7:0] hi, input int hp);
        drive_edge(m, 1'b0, lo);
        idle(hp);
        drive_edge(m, 1'b1, hi);
        idle(hp);
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int p0;
        n_checks = 0;
        n_errors = 0;
        pc       = 0;
        pops_d   = 0;
        pops_s   = 0;
        rand_rdy = 1'b0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        pclk_d   = 1'b1;
        pclk_s   = 1'b1;
        pdat_d   = '0;
        pdat_s   = '0;
        rdy_d    = 1'b0;
        rdy_s    = 1'b0;
        model_reset();
        idle(3);
        #1 rst_n = 1'b1;

        // Idle link after reset
        idle(20);
        check("rst_valid", {31'd0, val_d}, 32'd0);
        check("rst_data", {16'd0, dout_d}, 32'd0);
        check("rst_ovf", {31'd0, ovf_d}, 32'd0);
        check("rst_sdr_valid", {31'd0, val_s}, 32'd0);

        // DDR word 0xA5 / 0x3C, latency from the rising pin edge
        drive_edge(1'b0, 1'b0, 8'hA5);
        idle(4);
        drive_edge(1'b0, 1'b1, 8'h3C);
        idle(2);
        check("lat_early", {31'd0, val_d}, 32'd0);
        idle(1);
        check("lat_valid", {31'd0, val_d}, 32'd1);
        check("lat_data", {16'd0, dout_d}, 32'h3CA5);
        rdy_d = 1'b1;
        idle(1);
        rdy_d = 1'b0;
        idle(3);

        // SDR words in order
        rdy_s = 1'b1;
        p0    = pops_s;
        send_word(1'b1, 8'hEE, 8'h11, 4);
        send_word(1'b1, 8'hDD, 8'h22, 4);
        send_word(1'b1, 8'hCC, 8'h33, 4);
        idle(3);
        check("sdr_count", p0 < 0 ? 32'd0 : 32'(pops_s - p0), 32'd3);
        rdy_s = 1'b0;

        // Overflow: nine words into eight slots
        flush_pulse();
        rdy_d = 1'b0;
        repeat (9) send_word(1'b0, 8'($urandom), 8'($urandom), 3);
        idle(2);
        check("ovf_set", {31'd0, ovf_d}, 32'd1);
        p0    = pops_d;
        rdy_d = 1'b1;
        idle(10);
        rdy_d = 1'b0;
        check("ovf_drain", 32'(pops_d - p0), 32'd8);
        check("ovf_sticky", {31'd0, ovf_d}, 32'd1);
        flush_pulse();
        check("ovf_flush", {31'd0, ovf_d}, 32'd0);

        // Full FIFO with a pop on the push cycle
        repeat (8) send_word(1'b0, 8'($urandom), 8'($urandom), 3);
        drive_edge(1'b0, 1'b0, 8'h5A);
        idle(3);
        drive_edge(1'b0, 1'b1, 8'hC3);
        idle(2);
        rdy_d = 1'b1;
        idle(1);
        rdy_d = 1'b0;
        idle(2);
        check("full_pop_ovf", {31'd0, ovf_d}, 32'd0);
        p0    = pops_d;
        rdy_d = 1'b1;
        idle(12);
        rdy_d = 1'b0;
        check("full_pop_drain", 32'(pops_d - p0), 32'd8);

        // Reset between the fall and the rise of a word
        drive_edge(1'b0, 1'b0, 8'hAA);
        idle(5);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        pclk_d = 1'b1;
        pdat_d = '0;
        idle(3);
        #1 rst_n = 1'b1;
        idle(3);
        check("rst_mid_empty", {31'd0, val_d}, 32'd0);
        p0 = pops_d;
        send_word(1'b0, 8'h0F, 8'hF0, 3);
        idle(1);
        check("rst_mid_valid", {31'd0, val_d}, 32'd1);
        check("rst_mid_data", {16'd0, dout_d}, 32'hF00F);
        rdy_d = 1'b1;
        idle(1);
        rdy_d = 1'b0;
        idle(3);
        check("rst_mid_count", 32'(pops_d - p0), 32'd1);

        // Randomized traffic on both instances
        rand_rdy = 1'b1;
        repeat (80) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) flush_pulse();
            else send_word(r[0], 8'($urandom), 8'($urandom), int'($urandom_range(3, 6)));
        end
        rand_rdy = 1'b0;
        rdy_d    = 1'b1;
        rdy_s    = 1'b1;
        idle(20);
        check("end_empty_ddr", {31'd0, val_d}, 32'd0);
        check("end_empty_sdr", {31'd0, val_s}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
